// File: rtl/soc_estimator.sv
// Coulomb-counting state-of-charge estimator: integrates signed current samples
// into a residual accumulator and steps an 8-bit SoC percentage by at most 1% per cycle.
module soc_estimator #(
    parameter logic [31:0] COUNTS_PER_PCT = 32'd36000,
    parameter int          ACC_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] current_ma,
    input  logic               sample_valid,
    input  logic               soc_load,
    input  logic [7:0]         soc_load_value,
    output logic [7:0]         soc_percent,
    output logic               soc_valid,
    output logic               soc_update,
    output logic               soc_sat
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] CPP_POS  = ACC_W'(COUNTS_PER_PCT);
    localparam logic signed [ACC_W-1:0] CPP_NEG  = -CPP_POS;
    localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [7:0]              SOC_MAX  = 8'd100;

    state_t                  state_q, state_d;
    logic [7:0]              soc_q, soc_d;
    logic                    valid_q, valid_d;
    logic                    update_q, update_d;
    logic                    sat_q, sat_d;
    logic signed [ACC_W-1:0] residual_q, residual_d;

    logic signed [ACC_W-1:0] sample_ext_s;
    logic signed [ACC_W-1:0] addend_s;
    logic signed [ACC_W-1:0] r_sum_s;

    assign sample_ext_s = {{(ACC_W-16){current_ma[15]}}, current_ma};

    // Residual plus the incoming sample, if any.
    always_comb begin
        addend_s = ACC_ZERO;
        if (sample_valid) begin
            addend_s = sample_ext_s;
        end else begin
            addend_s = ACC_ZERO;
        end
        r_sum_s = residual_q + addend_s;
    end

    // Next-state logic: load has priority over integration and any pending step.
    always_comb begin
        state_d    = state_q;
        soc_d      = soc_q;
        valid_d    = valid_q;
        residual_d = residual_q;
        update_d   = 1'b0;
        sat_d      = 1'b0;

        if (soc_load) begin
            state_d    = ST_RUN;
            valid_d    = 1'b1;
            residual_d = ACC_ZERO;
            if (soc_load_value > SOC_MAX) begin
                soc_d = SOC_MAX;
            end else begin
                soc_d = soc_load_value;
            end
        end else begin
            case (state_q)
                ST_INIT: begin
                    residual_d = ACC_ZERO;
                end
                ST_RUN: begin
                    if (r_sum_s >= CPP_POS) begin
                        if (soc_q < SOC_MAX) begin
                            soc_d      = soc_q + 8'd1;
                            residual_d = r_sum_s - CPP_POS;
                            update_d   = 1'b1;
                        end else begin
                            // Full pack: surplus charge is discarded, not banked.
                            residual_d = ACC_ZERO;
                            sat_d      = 1'b1;
                        end
                    end else if (r_sum_s <= CPP_NEG) begin
                        if (soc_q > 8'd0) begin
                            soc_d      = soc_q - 8'd1;
                            residual_d = r_sum_s + CPP_POS;
                            update_d   = 1'b1;
                        end else begin
                            residual_d = ACC_ZERO;
                            sat_d      = 1'b1;
                        end
                    end else begin
                        residual_d = r_sum_s;
                    end
                end
                default: begin
                    state_d    = ST_INIT;
                    residual_d = ACC_ZERO;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            soc_q      <= 8'd0;
            valid_q    <= 1'b0;
            update_q   <= 1'b0;
            sat_q      <= 1'b0;
            residual_q <= ACC_ZERO;
        end else begin
            state_q    <= state_d;
            soc_q      <= soc_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            sat_q      <= sat_d;
            residual_q <= residual_d;
        end
    end

    assign soc_percent = soc_q;
    assign soc_valid   = valid_q;
    assign soc_update  = update_q;
    assign soc_sat     = sat_q;

endmodule

// File: tb/tb_soc_estimator.sv
// Scoreboard bench for soc_estimator (COUNTS_PER_PCT=1000): the driver queues the
// expected post-edge outputs for every cycle it drives; a monitor pops and compares.
module tb_soc_estimator;

    logic               clk;
    logic               rst;
    logic signed [15:0] current_ma;
    logic               sample_valid;
    logic               soc_load;
    logic [7:0]         soc_load_value;
    logic [7:0]         soc_percent;
    logic               soc_valid;
    logic               soc_update;
    logic               soc_sat;

    typedef struct {
        int         id;
        logic [7:0] soc;
        logic       valid;
        logic       upd;
        logic       sat;
        logic       chk_res;
        int         res;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    soc_estimator #(
        .COUNTS_PER_PCT(32'd1000),
        .ACC_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .current_ma(current_ma),
        .sample_valid(sample_valid),
        .soc_load(soc_load),
        .soc_load_value(soc_load_value),
        .soc_percent(soc_percent),
        .soc_valid(soc_valid),
        .soc_update(soc_update),
        .soc_sat(soc_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic r, input logic ld, input logic [7:0] lv,
                       input logic sv, input int cur,
                       input logic [7:0] es, input logic ev, input logic eu,
                       input logic esat, input int er);
        exp_t e;
        @(negedge clk);
        rst            = r;
        soc_load       = ld;
        soc_load_value = lv;
        sample_valid   = sv;
        current_ma     = 16'(cur);
        e.id      = step_id;
        e.soc     = es;
        e.valid   = ev;
        e.upd     = eu;
        e.sat     = esat;
        e.chk_res = 1'b1;
        e.res     = er;
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic idle(input logic [7:0] es, input logic ev, input logic eu,
                        input logic esat, input int er);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 0, es, ev, eu, esat, er);
    endtask

    task automatic smp(input int cur, input logic [7:0] es, input logic ev,
                       input logic eu, input logic esat, input int er);
        cyc(1'b0, 1'b0, 8'd0, 1'b1, cur, es, ev, eu, esat, er);
    endtask

    task automatic load(input logic [7:0] lv, input logic [7:0] es);
        cyc(1'b0, 1'b1, lv, 1'b0, 0, es, 1'b1, 1'b0, 1'b0, 0);
    endtask

    // Monitor: outputs are presented every cycle, compared 2 time units after the edge.
    always @(posedge clk) begin
        exp_t e;
        int   act_res;
        #2;
        if (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            act_res = int'(dut.residual_q);
            n_checks += 4;
            if (soc_percent !== e.soc) begin
                n_fail++;
                $display("FAIL soc_percent step %0d: got %0d expected %0d", e.id, soc_percent, e.soc);
            end
            if (soc_valid !== e.valid) begin
                n_fail++;
                $display("FAIL soc_valid step %0d: got %0b expected %0b", e.id, soc_valid, e.valid);
            end
            if (soc_update !== e.upd) begin
                n_fail++;
                $display("FAIL soc_update step %0d: got %0b expected %0b", e.id, soc_update, e.upd);
            end
            if (soc_sat !== e.sat) begin
                n_fail++;
                $display("FAIL soc_sat step %0d: got %0b expected %0b", e.id, soc_sat, e.sat);
            end
            if (e.chk_res) begin
                n_checks++;
                if (act_res != e.res) begin
                    n_fail++;
                    $display("FAIL residual step %0d: got %0d expected %0d", e.id, act_res, e.res);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        current_ma     = 16'sd0;
        sample_valid   = 1'b0;
        soc_load       = 1'b0;
        soc_load_value = 8'd0;

        // Reset state
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 0, 8'd0, 1'b0, 1'b0, 1'b0, 0);

        // Pre-seed: samples ignored in INIT
        for (int i = 0; i < 10; i++) smp(500, 8'd0, 1'b0, 1'b0, 1'b0, 0);

        // Charge step
        load(8'd50, 8'd50);
        smp(250, 8'd50, 1'b1, 1'b0, 1'b0, 250);
        smp(250, 8'd50, 1'b1, 1'b0, 1'b0, 500);
        smp(250, 8'd50, 1'b1, 1'b0, 1'b0, 750);
        smp(250, 8'd51, 1'b1, 1'b1, 1'b0, 0);
        idle(8'd51, 1'b1, 1'b0, 1'b0, 0);

        // Discharge with remainder, then exact -1000 boundary
        load(8'd10, 8'd10);
        smp(-600, 8'd10, 1'b1, 1'b0, 1'b0, -600);
        smp(-600, 8'd9, 1'b1, 1'b1, 1'b0, -200);
        smp(-800, 8'd8, 1'b1, 1'b1, 1'b0, 0);
        idle(8'd8, 1'b1, 1'b0, 1'b0, 0);

        // Catch-up: one step per cycle
        load(8'd20, 8'd20);
        smp(2500, 8'd21, 1'b1, 1'b1, 1'b0, 1500);
        idle(8'd22, 1'b1, 1'b1, 1'b0, 500);
        idle(8'd22, 1'b1, 1'b0, 1'b0, 500);
        idle(8'd22, 1'b1, 1'b0, 1'b0, 500);

        // Saturation at 100 and 0, and load clamp
        load(8'd100, 8'd100);
        smp(1000, 8'd100, 1'b1, 1'b0, 1'b1, 0);
        idle(8'd100, 1'b1, 1'b0, 1'b0, 0);
        load(8'd0, 8'd0);
        smp(-1000, 8'd0, 1'b1, 1'b0, 1'b1, 0);
        idle(8'd0, 1'b1, 1'b0, 1'b0, 0);
        load(8'd150, 8'd100);

        // Load beats a simultaneous sample
        cyc(1'b0, 1'b1, 8'd40, 1'b1, 5000, 8'd40, 1'b1, 1'b0, 1'b0, 0);
        idle(8'd40, 1'b1, 1'b0, 1'b0, 0);

        // Reset mid catch-up, then samples ignored until a load
        smp(5000, 8'd41, 1'b1, 1'b1, 1'b0, 4000);
        idle(8'd42, 1'b1, 1'b1, 1'b0, 3000);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 0, 8'd0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) smp(2000, 8'd0, 1'b0, 1'b0, 1'b0, 0);

        // Re-seed and hit the +/- threshold from just inside
        load(8'd30, 8'd30);
        smp(-999, 8'd30, 1'b1, 1'b0, 1'b0, -999);
        smp(-1, 8'd29, 1'b1, 1'b1, 1'b0, 0);
        smp(999, 8'd29, 1'b1, 1'b0, 1'b0, 999);
        smp(1, 8'd30, 1'b1, 1'b1, 1'b0, 0);
        idle(8'd30, 1'b1, 1'b0, 1'b0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
